// File: rtl/mips_pkg.sv
// Shared definitions for the CPU control path: opcodes seen at jump control,
// the interrupt vector address and the interrupt controller FSM state type.
package mips_pkg;

  localparam logic [5:0] OP_RET = 6'b010000;
  localparam logic [5:0] OP_JMP = 6'b011000;
  localparam logic [5:0] OP_JV  = 6'b011100;
  localparam logic [5:0] OP_JNV = 6'b011101;
  localparam logic [5:0] OP_JZ  = 6'b011110;
  localparam logic [5:0] OP_JNZ = 6'b011111;

  // Jump control redirects here on an accepted interrupt.
  localparam logic [15:0] IRQ_VECTOR = 16'hF000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIRE    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_SERVICE = 2'd3
  } irq_state_t;

  // True for any opcode that is about to use the return-address/flags path.
  function automatic logic is_flow_op(input logic [5:0] op);
    return (op == OP_RET) || (op == OP_JMP) || (op == OP_JV) ||
           (op == OP_JNV) || (op == OP_JZ)  || (op == OP_JNZ);
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for the interrupt request lines.
// Define IRQ_SYNC_EN to insert a 2-flop synchronizer ahead of the detector.
module irq_edge_detect #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_src,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] r_src_q;

`ifdef IRQ_SYNC_EN
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = i_src;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src_q <= '0;
    end else begin
      r_src_q <= w_src;
    end
  end

  assign o_edge = w_src & ~r_src_q;

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latched, masked, fixed-priority interrupt controller feeding jump control.
// Optional IRQ_SYNC_EN adds input synchronizers (2 extra cycles of latency).
module interrupt_controller
  import mips_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int HOLDOFF = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [5:0]         op,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic               interrupt,
  output logic [3:0]         irq_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic [1:0]         o_dbg_state
);

  localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLDOFF - 1);

  irq_state_t         r_state;
  irq_state_t         w_state_nxt;
  logic [HCW-1:0]     r_hold_cnt;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_pending;
  logic [3:0]         r_irq_id;

  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_grant_vec;
  logic [NUM_SRC-1:0] w_clr;
  logic [3:0]         w_grant_idx;
  logic               w_fire;

  irq_edge_detect #(
    .WIDTH (NUM_SRC)
  ) u_edge (
    .clk    (clk),
    .reset  (reset),
    .i_src  (irq_src),
    .o_edge (w_edge)
  );

  // Grant always sees the registered mask, so a same-cycle mask write is not yet visible.
  assign w_req = r_pending & r_mask;

  always_comb begin
    w_grant_idx = '0;
    w_grant_vec = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_grant_idx    = 4'(i);
        w_grant_vec    = '0;
        w_grant_vec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((|w_req) && !is_flow_op(op)) begin
          w_state_nxt = ST_FIRE;
          w_fire      = 1'b1;
        end
      end
      ST_FIRE: w_state_nxt = ST_HOLD;
      // RET is deliberately not looked at while jump control is still capturing flags.
      ST_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (op == OP_RET) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold_cnt <= '0;
    end else if (r_state == ST_HOLD) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end else begin
      r_hold_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask <= '0;
    end else if (mask_we) begin
      r_mask <= mask_wdata;
    end
  end

  // A new edge on the granted source is ORed in after the clear, so it survives.
  assign w_clr = w_fire ? w_grant_vec : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_id <= '0;
    end else if (w_fire) begin
      r_irq_id <= w_grant_idx;
    end
  end

  // interrupt is a state decode: one cycle wide, no path from irq_src, no ready.
  assign interrupt   = (r_state == ST_FIRE);
  assign in_service  = (r_state != ST_IDLE);
  assign irq_id      = r_irq_id;
  assign pending     = r_pending;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed, table-driven bench for interrupt_controller (default build, 4 sources).
module tb_interrupt_controller;

  localparam logic [5:0] T_NOP = 6'b000000;
  localparam logic [5:0] T_RET = 6'b010000;
  localparam logic [5:0] T_JMP = 6'b011000;
  localparam logic [5:0] T_JNZ = 6'b011111;

  logic       clk;
  logic       reset;
  logic [3:0] irq_src;
  logic [5:0] op;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       interrupt;
  logic [3:0] irq_id;
  logic       in_service;
  logic [3:0] pending;
  logic [1:0] o_dbg_state;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [3:0] irq;
    logic [5:0] op;
    logic       we;
    logic [3:0] wd;
    logic       e_int;
    logic [3:0] e_id;
    logic       e_ins;
    logic [3:0] e_pend;
  } vec_t;

  vec_t vecs[$];
  logic [3:0] exp_q[$];

  interrupt_controller #(
    .NUM_SRC (4),
    .HOLDOFF (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_src     (irq_src),
    .op          (op),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .interrupt   (interrupt),
    .irq_id      (irq_id),
    .in_service  (in_service),
    .pending     (pending),
    .o_dbg_state (o_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] irq, input logic [5:0] o, input logic we,
                              input logic [3:0] wd, input logic e_int, input logic [3:0] e_id,
                              input logic e_ins, input logic [3:0] e_pend);
    vec_t v;
    v.irq = irq; v.op = o; v.we = we; v.wd = wd;
    v.e_int = e_int; v.e_id = e_id; v.e_ins = e_ins; v.e_pend = e_pend;
    return v;
  endfunction

  // Drive at a negedge, let one posedge consume it, compare at the next negedge.
  task automatic apply_vec(input string tag, input vec_t v);
    irq_src    = v.irq;
    op         = v.op;
    mask_we    = v.we;
    mask_wdata = v.wd;
    @(negedge clk);
    check({tag, ".interrupt"},  32'(interrupt),  32'(v.e_int));
    check({tag, ".irq_id"},     32'(irq_id),     32'(v.e_id));
    check({tag, ".in_service"}, 32'(in_service), 32'(v.e_ins));
    check({tag, ".pending"},    32'(pending),    32'(v.e_pend));
  endtask

  // Scoreboard: every interrupt pulse must carry the next expected source index.
  always @(negedge clk) begin
    if (reset && interrupt) begin
      if (exp_q.size() == 0) begin
        check("sb.unexpected_pulse", 32'(irq_id), 32'hFFFF_FFFF);
      end else begin
        check("sb.irq_id", 32'(irq_id), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    irq_src = '0; op = T_NOP; mask_we = 1'b0; mask_wdata = '0;

    exp_q.push_back(4'd2);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd2);

    // irq, op, we, wdata | interrupt, irq_id, in_service, pending
    // mask 0101, source 2 pulses; RET during HOLD ignored, accepted in SERVICE
    vecs.push_back(mk(4'b0000, T_NOP, 1, 4'b0101, 0, 4'd0, 0, 4'b0000));
    vecs.push_back(mk(4'b0100, T_NOP, 0, 4'b0000, 0, 4'd0, 0, 4'b0100));
    vecs.push_back(mk(4'b0100, T_NOP, 0, 4'b0000, 1, 4'd2, 1, 4'b0000));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd2, 1, 4'b0000));
    vecs.push_back(mk(4'b0000, T_RET, 0, 4'b0000, 0, 4'd2, 1, 4'b0000));
    vecs.push_back(mk(4'b0000, T_RET, 0, 4'b0000, 0, 4'd2, 1, 4'b0000));
    vecs.push_back(mk(4'b0000, T_RET, 0, 4'b0000, 0, 4'd2, 0, 4'b0000));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd2, 0, 4'b0000));
    // mask 1111, sources 3 and 1 together: 1 first, 3 right after RET
    vecs.push_back(mk(4'b0000, T_NOP, 1, 4'b1111, 0, 4'd2, 0, 4'b0000));
    vecs.push_back(mk(4'b1010, T_NOP, 0, 4'b0000, 0, 4'd2, 0, 4'b1010));
    vecs.push_back(mk(4'b1010, T_NOP, 0, 4'b0000, 1, 4'd1, 1, 4'b1000));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd1, 1, 4'b1000));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd1, 1, 4'b1000));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd1, 1, 4'b1000));
    vecs.push_back(mk(4'b0000, T_RET, 0, 4'b0000, 0, 4'd1, 0, 4'b1000));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 1, 4'd3, 1, 4'b0000));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd3, 1, 4'b0000));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd3, 1, 4'b0000));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd3, 1, 4'b0000));
    vecs.push_back(mk(4'b0000, T_RET, 0, 4'b0000, 0, 4'd3, 0, 4'b0000));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd3, 0, 4'b0000));
    // mask 0: source 0 latches pending only; mask write uses old mask that cycle
    vecs.push_back(mk(4'b0000, T_NOP, 1, 4'b0000, 0, 4'd3, 0, 4'b0000));
    vecs.push_back(mk(4'b0001, T_NOP, 0, 4'b0000, 0, 4'd3, 0, 4'b0001));
    vecs.push_back(mk(4'b0001, T_NOP, 0, 4'b0000, 0, 4'd3, 0, 4'b0001));
    vecs.push_back(mk(4'b0001, T_NOP, 1, 4'b0001, 0, 4'd3, 0, 4'b0001));
    vecs.push_back(mk(4'b0001, T_NOP, 0, 4'b0000, 1, 4'd0, 1, 4'b0000));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd0, 1, 4'b0000));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd0, 1, 4'b0000));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd0, 1, 4'b0000));
    vecs.push_back(mk(4'b0000, T_RET, 0, 4'b0000, 0, 4'd0, 0, 4'b0000));
    // jumps/RET block FIRE in IDLE; re-edge on granted source keeps pending set
    vecs.push_back(mk(4'b0001, T_JMP, 0, 4'b0000, 0, 4'd0, 0, 4'b0001));
    vecs.push_back(mk(4'b0000, T_JNZ, 0, 4'b0000, 0, 4'd0, 0, 4'b0001));
    vecs.push_back(mk(4'b0000, T_RET, 0, 4'b0000, 0, 4'd0, 0, 4'b0001));
    vecs.push_back(mk(4'b0001, T_NOP, 0, 4'b0000, 1, 4'd0, 1, 4'b0001));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd0, 1, 4'b0001));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd0, 1, 4'b0001));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd0, 1, 4'b0001));
    vecs.push_back(mk(4'b0000, T_RET, 0, 4'b0000, 0, 4'd0, 0, 4'b0001));
    vecs.push_back(mk(4'b0000, T_NOP, 0, 4'b0000, 1, 4'd0, 1, 4'b0000));
    // masked sources accumulate during service; end parked in SERVICE
    vecs.push_back(mk(4'b0110, T_NOP, 0, 4'b0000, 0, 4'd0, 1, 4'b0110));
    vecs.push_back(mk(4'b0110, T_NOP, 0, 4'b0000, 0, 4'd0, 1, 4'b0110));
    vecs.push_back(mk(4'b0110, T_NOP, 0, 4'b0000, 0, 4'd0, 1, 4'b0110));

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.interrupt",  32'(interrupt),   32'd0);
    check("rst.irq_id",     32'(irq_id),      32'd0);
    check("rst.in_service", 32'(in_service),  32'd0);
    check("rst.pending",    32'(pending),     32'd0);
    check("rst.state",      32'(o_dbg_state), 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      apply_vec($sformatf("v%0d", i), vecs[i]);
    end
    check("pre_rst.state_service", 32'(o_dbg_state), 32'd3);

    // Asynchronous reset mid-service with pending 0110
    reset   = 1'b0;
    irq_src = '0;
    op      = T_NOP;
    #1;
    check("midrst.interrupt",  32'(interrupt),   32'd0);
    check("midrst.irq_id",     32'(irq_id),      32'd0);
    check("midrst.in_service", 32'(in_service),  32'd0);
    check("midrst.pending",    32'(pending),     32'd0);
    check("midrst.state",      32'(o_dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Mask came back as 0: a new edge only pends until the mask is rewritten
    apply_vec("r0", mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd0, 0, 4'b0000));
    apply_vec("r1", mk(4'b0100, T_NOP, 0, 4'b0000, 0, 4'd0, 0, 4'b0100));
    apply_vec("r2", mk(4'b0100, T_NOP, 0, 4'b0000, 0, 4'd0, 0, 4'b0100));
    apply_vec("r3", mk(4'b0100, T_NOP, 0, 4'b0000, 0, 4'd0, 0, 4'b0100));
    apply_vec("r4", mk(4'b0100, T_NOP, 1, 4'b0100, 0, 4'd0, 0, 4'b0100));
    apply_vec("r5", mk(4'b0100, T_NOP, 0, 4'b0000, 1, 4'd2, 1, 4'b0000));
    apply_vec("r6", mk(4'b0000, T_NOP, 0, 4'b0000, 0, 4'd2, 1, 4'b0000));

    check("sb.all_grants_seen", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
